// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes
// and a counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_piso.sv
// Load/shift register for the transmit byte; parity is frozen at load time
// so it never depends on how far the data has been shifted out.
module tx_piso #(
    parameter int   DATA_BITS = 8,
    parameter logic ODD       = 1'b0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 shift,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 bit0,
    output logic                 bit1,
    output logic                 parity
);

    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shreg  <= '0;
            parity <= 1'b0;
        end else if (clr) begin
            shreg  <= '0;
            parity <= 1'b0;
        end else if (load) begin
            shreg  <= data_in;
            parity <= (^data_in) ^ ODD;
        end else if (shift) begin
            shreg  <= shreg >> 1;
        end
    end

    // bit1 lets the FSM register the upcoming bit on the same edge that shifts.
    assign bit0 = shreg[0];
    assign bit1 = shreg[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// with a registered line output and a programmable baud divisor.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 tx_arst_n,
    input  logic                 tx_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    tx_state_t         state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [BIT_W-1:0]  bit_cnt, bit_next;
    logic              tx_next;
    logic              baud_last;
    logic              load, shift;
    logic              sr_bit0, sr_bit1, parity_bit;

    tx_piso #(
        .DATA_BITS (DATA_BITS),
        .ODD       (PAR_MODE)
    ) u_piso (
        .clk     (clk),
        .arst_n  (tx_arst_n),
        .clr     (tx_rst),
        .load    (load),
        .shift   (shift),
        .data_in (data_in),
        .bit0    (sr_bit0),
        .bit1    (sr_bit1),
        .parity  (parity_bit)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge tx_arst_n) begin
        if (!tx_arst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else if (tx_rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            tx       <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        load       = 1'b0;
        shift      = 1'b0;
        tx_next    = 1'b1;

        if (state != ST_IDLE) begin
            baud_next = baud_last ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    load       = 1'b1;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (baud_last) begin
                    shift = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (baud_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // The line is registered, so it follows the state being entered.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift ? sr_bit1 : sr_bit0;
            ST_PARITY: tx_next = parity_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    assign tx_busy = (state != ST_IDLE);
    assign tx_done = (state == ST_STOP) && baud_last;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity, even, odd) at 4 clocks/bit,
// a frame-level reference model checked every cycle, plus literal checks.
module tb_uart_tx;

    localparam int C = 4;

    logic       clk       = 1'b0;
    logic       tx_arst_n = 1'b0;
    logic       tx_rst    = 1'b0;
    logic       tx_start  = 1'b0;
    logic [7:0] data_in   = 8'h00;
    logic [2:0] tx_v, busy_v, done_v;

    int tests = 0;
    int fails = 0;

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
        .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_start(tx_start),
        .data_in(data_in), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_ev (
        .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_start(tx_start),
        .data_in(data_in), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_od (
        .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_start(tx_start),
        .data_in(data_in), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of bit values, each lasting C cycles.
    logic [11:0] m_bits [3];
    int          m_pos  [3] = '{0, 0, 0};
    bit          m_act  [3] = '{0, 0, 0};
    int          m_len  [3] = '{10, 11, 11};
    bit          m_par  [3] = '{0, 1, 1};
    bit          m_odd  [3] = '{0, 0, 1};

    function automatic logic [11:0] build_frame(input logic [7:0] d, input bit par, input bit odd);
        logic [11:0] f = '1;
        f[0] = 1'b0;
        for (int j = 0; j < 8; j++) f[1 + j] = d[j];
        if (par) f[9] = (^d) ^ odd;
        return f;
    endfunction

    always @(negedge clk) begin
        logic et, eb, ed;
        for (int i = 0; i < 3; i++) begin
            if (!tx_arst_n) m_act[i] = 1'b0;
            et = m_act[i] ? m_bits[i][m_pos[i] / C] : 1'b1;
            eb = m_act[i];
            ed = m_act[i] && (m_pos[i] == m_len[i] * C - 1);
            check_output($sformatf("model_tx[%0d]", i), tx_v[i], et);
            check_output($sformatf("model_busy[%0d]", i), busy_v[i], eb);
            check_output($sformatf("model_done[%0d]", i), done_v[i], ed);
            if (!tx_arst_n || tx_rst) begin
                m_act[i] = 1'b0;
            end else if (m_act[i]) begin
                if (m_pos[i] == m_len[i] * C - 1) m_act[i] = 1'b0;
                else m_pos[i]++;
            end else if (tx_start) begin
                m_bits[i] = build_frame(data_in, m_par[i], m_odd[i]);
                m_pos[i]  = 0;
                m_act[i]  = 1'b1;
            end
        end
    end

    logic [127:0] cap_tx   [3];
    logic [127:0] cap_busy [3];
    logic [127:0] cap_done [3];

    // Starts a frame; on return we are 1 ns into the first start-bit cycle.
    task automatic apply_stimulus(input logic [7:0] d, input bit hold);
        @(posedge clk); #1;
        tx_start = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        if (!hold) tx_start = 1'b0;
    endtask

    // Records n cycles; inputs change 1 ns after the edge at the chosen cycle indices.
    task automatic capture(input int n, input int s_on, input int s_off, input logic [7:0] d,
                           input int r_on, input int r_off);
        for (int i = 0; i < 3; i++) begin
            cap_tx[i] = '0; cap_busy[i] = '0; cap_done[i] = '0;
        end
        for (int k = 0; k < n; k++) begin
            if (k == s_on) begin tx_start = 1'b1; data_in = d; end
            if (k == s_off) tx_start = 1'b0;
            if (k == r_on) tx_rst = 1'b1;
            if (k == r_off) tx_rst = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                cap_tx[i][k]   = tx_v[i];
                cap_busy[i][k] = busy_v[i];
                cap_done[i][k] = done_v[i];
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic int first_done(input int i, input int from);
        for (int k = from; k < 128; k++) if (cap_done[i][k]) return k;
        return -1;
    endfunction

    function automatic int count_done(input int i);
        int c = 0;
        for (int k = 0; k < 128; k++) if (cap_done[i][k]) c++;
        return c;
    endfunction

    initial begin
        logic [9:0] exp_a5;
        int lows;
        exp_a5 = 10'b1101001010;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("reset_tx[%0d]", i), tx_v[i], 1'b1);
            check_output($sformatf("reset_busy[%0d]", i), busy_v[i], 1'b0);
            check_output($sformatf("reset_done[%0d]", i), done_v[i], 1'b0);
        end
        tx_arst_n = 1'b1;

        apply_stimulus(8'hA5, 0);
        capture(48, -1, -1, 8'h00, -1, -1);
        for (int k = 0; k < 40; k++)
            check_output($sformatf("a5_bit_k%0d", k), cap_tx[0][k], exp_a5[k / C]);
        check_int("a5_done_np", first_done(0, 0), 39);
        check_int("a5_done_ev", first_done(1, 0), 43);

        apply_stimulus(8'h07, 0);
        capture(48, -1, -1, 8'h00, -1, -1);
        check_output("par_even_07", cap_tx[1][37], 1'b1);
        check_output("par_odd_07", cap_tx[2][37], 1'b0);
        check_output("par_stop_ev", cap_tx[1][41], 1'b1);
        check_int("par_done_ev", first_done(1, 0), 43);
        check_int("par_done_od", first_done(2, 0), 43);

        apply_stimulus(8'h55, 0);
        capture(64, 12, 13, 8'h3C, -1, -1);
        check_int("busy_start_dones_np", count_done(0), 1);
        check_int("busy_start_dones_ev", count_done(1), 1);
        lows = 0;
        for (int k = 40; k < 64; k++) if (!cap_tx[0][k]) lows++;
        check_int("busy_start_no_frame_np", lows, 0);

        apply_stimulus(8'h01, 1);
        capture(100, 0, 48, 8'h80, -1, -1);
        check_int("b2b_done1_np", first_done(0, 0), 39);
        check_output("b2b_gap_np", cap_tx[0][40], 1'b1);
        check_output("b2b_start2_np", cap_tx[0][41], 1'b0);
        check_output("b2b_d0_first", cap_tx[0][5], 1'b1);
        check_output("b2b_d7_second", cap_tx[0][74], 1'b1);
        check_int("b2b_done2_np", first_done(0, 40), 80);
        check_output("b2b_gap_ev", cap_tx[1][44], 1'b1);
        check_output("b2b_start2_ev", cap_tx[1][45], 1'b0);
        check_int("b2b_done2_ev", first_done(1, 44), 88);

        apply_stimulus(8'h55, 0);
        capture(30, -1, -1, 8'h00, 17, 18);
        check_output("srst_before_tx", cap_tx[0][17], 1'b0);
        check_output("srst_tx", cap_tx[0][18], 1'b1);
        check_output("srst_busy", cap_busy[0][18], 1'b0);
        check_output("srst_busy_ev", cap_busy[1][18], 1'b0);
        check_int("srst_no_done", count_done(0) + count_done(1) + count_done(2), 0);

        apply_stimulus(8'hFF, 0);
        capture(48, -1, -1, 8'h00, -1, -1);
        for (int b = 0; b < 10; b++)
            check_output($sformatf("ff_bit%0d", b), cap_tx[0][b * C + 2], (b == 0) ? 1'b0 : 1'b1);
        check_int("ff_done_np", first_done(0, 0), 39);

        apply_stimulus(8'h5A, 0);
        check_output("arst_pre_tx", tx_v[0], 1'b0);
        #2;
        tx_arst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("arst_tx[%0d]", i), tx_v[i], 1'b1);
            check_output($sformatf("arst_busy[%0d]", i), busy_v[i], 1'b0);
            check_output($sformatf("arst_done[%0d]", i), done_v[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        tx_arst_n = 1'b1;

        apply_stimulus(8'hC3, 0);
        capture(48, -1, -1, 8'h00, -1, -1);
        check_output("c3_start", cap_tx[0][1], 1'b0);
        check_output("c3_d0", cap_tx[0][5], 1'b1);
        check_output("c3_d2", cap_tx[0][13], 1'b0);
        check_int("c3_done_np", first_done(0, 0), 39);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: the parallel-to-serial counterpart of the UART receive path. Accepts one byte per `tx_start` handshake and serialises it as a standard asynchronous frame (start bit, data LSB first, optional parity, one stop bit) on `tx`, with a programmable baud divisor. Sits between the host-side byte source and the pad; the line idles high.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per bit period. Must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, range 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN` = 0.

Ports:
- `clk` in 1: the single clock. Everything is rising-edge.
- `tx_arst_n` in 1: asynchronous, active-low reset.
- `tx_rst` in 1: synchronous clear, active high.
- `tx_start` in 1: request to send `data_in`. Sampled only when `tx_busy` = 0.
- `data_in` in `DATA_BITS`: byte to send. Captured on the accepted `tx_start` cycle.
- `tx` out 1: serial line. Registered.
- `tx_busy` out 1: high from the cycle after acceptance through the last stop-bit cycle.
- `tx_done` out 1: one-cycle pulse during the last clock of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The encoding is 3-bit binary.
- IDLE:
  - `tx`=1, `tx_busy`=0.
  - `tx_start`=1 latches `data_in` into the shift register, clears the counters and moves to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA:
  - `tx` = shift register bit 0. The register shifts right once per bit period.
  - The bit counter goes 0..`DATA_BITS`-1.
  - After the last bit, go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `tx` = XOR of the latched data, inverted if `PARITY_ODD`. The parity is computed at capture, not from shifted data. Lasts one bit period, then STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. `tx_done`=1 on the final cycle, then IDLE.
- The baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. Widths:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits.
  - Bit counter: `$clog2(DATA_BITS)+1` bits.
- `tx_start` while busy, including the `tx_done` cycle, is ignored. There is no queue and no error flag.
- `data_in` changes after acceptance have no effect on the frame in flight.
- Reset priority: `tx_arst_n` over `tx_rst` over normal operation.
- Reset values, for both resets: state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, counters=0, shift register=0.
- Reset mid-frame:
  - Asynchronous reset: `tx` goes high immediately.
  - `tx_rst`: `tx` goes high at the next edge.
  - In both cases the frame is truncated and `tx_done` is not pulsed.

## Timing
- Acceptance edge N (`tx_start`=1, IDLE) gives `tx`=0 and `tx_busy`=1 from cycle N+1.
- Frame length F = (2 + `DATA_BITS` + `PARITY_EN`) × `CLKS_PER_BIT` cycles, counted from the first low cycle.
- `tx_done` is high in cycle N+F. `tx_busy`=0 from N+F+1.
- Back-to-back: a `tx_start` held high is accepted at N+F+1, so the next start bit begins at N+F+2. The line stays high for exactly one cycle between frames.
- Each bit value is held for exactly `CLKS_PER_BIT` cycles, with no jitter.

## Structure
- Shared package `uart_pkg`:
  - the state enum;
  - the parity-mode constants;
  - a `clog2`-based width helper.
- Sub-module `tx_piso`: the load/shift register plus the parity computation. It has a load enable, a shift enable and a serial bit-0 output.
- The FSM and both counters live in `uart_tx`.

## Test plan
- **Basic byte.** `CLKS_PER_BIT`=4, no parity, send 0xA5.
  - `tx` must be 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `tx_done` pulses 40 cycles after the first low.
- **Parity.** `PARITY_EN`=1.
  - Even parity, send 0x07: parity bit = 1.
  - Odd parity, send 0x07: parity bit = 0.
  - F = 44 cycles at `CLKS_PER_BIT`=4.
- **Start while busy.** Pulse `tx_start` with 0x3C mid-frame while sending 0x55.
  - The frame is unchanged, exactly one `tx_done` occurs, and no second frame follows.
- **Back-to-back.** Hold `tx_start`=1 with 0x01 then 0x80.
  - Two complete frames, separated by exactly one high cycle after `tx_done`.
- **Synchronous reset.** Assert `tx_rst` during DATA bit 3.
  - Next edge: `tx`=1, `tx_busy`=0, no `tx_done`.
  - A following 0xFF frame is transmitted correctly.
- **Asynchronous reset.** Drop `tx_arst_n` mid-START, off a clock edge.
  - `tx`=1 immediately; all outputs at reset values.
  - Normal operation resumes after release.
